// File: rtl/frequency_generator_pkg.sv
// Shared types and tone-length helpers for the FSK square-wave burst generator.
// Build option: FREQUENCY_GENERATOR_EXACT_PERIOD_EN makes each period exactly CLOCK/FREQ cycles.
package frequency_generator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int tone_ticks(input int clock_hz, input int freq_hz);
    return clock_hz / freq_hz;
  endfunction

  function automatic int tone_half(input int clock_hz, input int freq_hz);
    return tone_ticks(clock_hz, freq_hz) / 2;
  endfunction

  // With the exact-period option the odd leftover cycle goes to the high phase.
  function automatic int tone_high_len(input int clock_hz, input int freq_hz);
`ifdef FREQUENCY_GENERATOR_EXACT_PERIOD_EN
    return tone_ticks(clock_hz, freq_hz) - tone_half(clock_hz, freq_hz);
`else
    return tone_half(clock_hz, freq_hz);
`endif
  endfunction

  function automatic int tone_low_len(input int clock_hz, input int freq_hz);
    return tone_half(clock_hz, freq_hz);
  endfunction

endpackage

// File: rtl/frequency_generator_half_period_timer.sv
// Up-counter timing one half-phase of the tone; shared by the HIGH and LOW phases.
module half_period_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clock_i,
  input  logic             clear_i,
  input  logic             restart_i,
  input  logic [WIDTH-1:0] length_i,
  output logic             terminal_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = restart_i ? '0 : count_q + WIDTH'(1);
  end

  // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock_i or posedge clear_i) begin
    if (clear_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal_o = (count_q == length_i - WIDTH'(1));

endmodule

// File: rtl/frequency_generator.sv
// Start/busy/done burst generator emitting a square wave at FREQUENCY_1 or FREQUENCY_2.
// Build option: FREQUENCY_GENERATOR_EXACT_PERIOD_EN (high phase takes the ceil half).
module frequency_generator
  import frequency_generator_pkg::*;
#(
  parameter int FREQUENCY_1   = 9000,
  parameter int FREQUENCY_2   = 11000,
  parameter int CLOCK         = 50000000,
  parameter int COUNTER_WIDTH = 16,
  parameter int PERIODS_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     enable,
  input  logic                     start,
  input  logic                     select,
  input  logic [PERIODS_WIDTH-1:0] periods,
  output logic                     out,
  output logic                     busy,
  output logic                     done
);

  localparam int TICKS1 = tone_ticks(CLOCK, FREQUENCY_1);
  localparam int TICKS2 = tone_ticks(CLOCK, FREQUENCY_2);
  localparam int HALF1  = tone_half(CLOCK, FREQUENCY_1);
  localparam int HALF2  = tone_half(CLOCK, FREQUENCY_2);

  localparam logic [COUNTER_WIDTH-1:0] HIGH_LEN1 = COUNTER_WIDTH'(tone_high_len(CLOCK, FREQUENCY_1));
  localparam logic [COUNTER_WIDTH-1:0] HIGH_LEN2 = COUNTER_WIDTH'(tone_high_len(CLOCK, FREQUENCY_2));
  localparam logic [COUNTER_WIDTH-1:0] LOW_LEN1  = COUNTER_WIDTH'(tone_low_len(CLOCK, FREQUENCY_1));
  localparam logic [COUNTER_WIDTH-1:0] LOW_LEN2  = COUNTER_WIDTH'(tone_low_len(CLOCK, FREQUENCY_2));

  if (HALF1 < 1 || HALF2 < 1 ||
      longint'(TICKS1) >= (longint'(1) << COUNTER_WIDTH) ||
      longint'(TICKS2) >= (longint'(1) << COUNTER_WIDTH)) begin : g_bad_params
    $error("frequency_generator: tone half-period below 1 or period exceeds COUNTER_WIDTH");
  end

  state_e                     state_q;
  logic                       select_q;
  logic [PERIODS_WIDTH-1:0]   periods_q;
  logic [PERIODS_WIDTH-1:0]   pcount_q;
  logic [PERIODS_WIDTH-1:0]   pcount_d;
  logic                       out_q;
  logic                       busy_q;
  logic                       done_q;
  logic [COUNTER_WIDTH-1:0]   phase_len;
  logic                       terminal;
  logic                       restart;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    phase_len = select_q ? LOW_LEN2 : LOW_LEN1;
    if (state_q == HIGH) begin
      phase_len = select_q ? HIGH_LEN2 : HIGH_LEN1;
    end
    restart  = !enable || terminal || (state_q != HIGH && state_q != LOW);
    pcount_d = pcount_q + PERIODS_WIDTH'(1);
  end

  half_period_timer #(
    .WIDTH(COUNTER_WIDTH)
  ) u_timer (
    .clock_i    (clock),
    .clear_i    (clear),
    .restart_i  (restart),
    .length_i   (phase_len),
    .terminal_o (terminal)
  );

  // Outputs are registered alongside the state, so they follow it by zero extra cycles.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= IDLE;
      select_q  <= 1'b0;
      periods_q <= '0;
      pcount_q  <= '0;
      out_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (!enable) begin
      state_q  <= IDLE;
      pcount_q <= '0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            select_q  <= select;
            periods_q <= periods;
            pcount_q  <= '0;
            state_q   <= HIGH;
            out_q     <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        HIGH: begin
          if (terminal) begin
            state_q <= LOW;
            out_q   <= 1'b0;
          end
        end
        LOW: begin
          if (terminal) begin
            pcount_q <= pcount_d;
            if (periods_q != '0 && pcount_d == periods_q) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              out_q   <= 1'b0;
            end else begin
              state_q <= HIGH;
              out_q   <= 1'b1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          out_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          out_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_frequency_generator.sv
// Directed bench for frequency_generator: table-driven bursts plus hand-written corner sequences.
// Scaled tones: CLOCK=1000, FREQUENCY_1=100 (5/5), FREQUENCY_2=300 (1/1, or 2/1 with exact period).
module tb_frequency_generator;

  localparam int CLK_HZ = 1000;
  localparam int F1     = 100;
  localparam int F2     = 300;
  localparam int PW     = 8;
  localparam int H1     = 5;
  localparam int L1     = 5;
`ifdef FREQUENCY_GENERATOR_EXACT_PERIOD_EN
  localparam int H2     = 2;
`else
  localparam int H2     = 1;
`endif
  localparam int L2     = 1;

  typedef struct {
    logic          sel;
    logic [PW-1:0] per;
    int            high_len;
    int            low_len;
  } vec_t;

  logic          clock   = 1'b0;
  logic          clear   = 1'b1;
  logic          enable  = 1'b0;
  logic          start   = 1'b0;
  logic          select  = 1'b0;
  logic [PW-1:0] periods = '0;
  logic          out;
  logic          busy;
  logic          done;

  int checks   = 0;
  int failures = 0;

  vec_t vecs [4];

  frequency_generator #(
    .FREQUENCY_1   (F1),
    .FREQUENCY_2   (F2),
    .CLOCK         (CLK_HZ),
    .COUNTER_WIDTH (16),
    .PERIODS_WIDTH (PW)
  ) dut (
    .clock   (clock),
    .clear   (clear),
    .enable  (enable),
    .start   (start),
    .select  (select),
    .periods (periods),
    .out     (out),
    .busy    (busy),
    .done    (done)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0b expected=%0b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_out"},  out,  1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  // One full burst; optional ignored start mid-burst and start held through the DONE cycle.
  task automatic run_burst(input int id, input logic sel, input logic [PW-1:0] per,
                           input int h, input int l, input int disturb_at,
                           input bit start_in_done);
    int total;
    total   = int'(per) * (h + l);
    select  = sel;
    periods = per;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int k = 0; k < total; k++) begin
      check($sformatf("v%0d_k%0d_out", id, k),  out,  ((k % (h + l)) < h) ? 1'b1 : 1'b0);
      check($sformatf("v%0d_k%0d_busy", id, k), busy, 1'b1);
      check($sformatf("v%0d_k%0d_done", id, k), done, 1'b0);
      if (k == disturb_at) begin
        start   = 1'b1;
        select  = ~sel;
        periods = 8'd9;
      end
      tick();
      if (k == disturb_at) start = 1'b0;
    end
    check($sformatf("v%0d_end_done", id), done, 1'b1);
    check($sformatf("v%0d_end_busy", id), busy, 1'b0);
    check($sformatf("v%0d_end_out", id),  out,  1'b0);
    if (start_in_done) start = 1'b1;
    tick();
    check_idle($sformatf("v%0d_after", id));
  endtask

  initial begin
    vecs[0] = '{sel: 1'b0, per: 8'd3,   high_len: H1, low_len: L1};
    vecs[1] = '{sel: 1'b1, per: 8'd2,   high_len: H2, low_len: L2};
    vecs[2] = '{sel: 1'b0, per: 8'd1,   high_len: H1, low_len: L1};
    vecs[3] = '{sel: 1'b1, per: 8'd255, high_len: H2, low_len: L2};

    #12;
    check_idle("reset");
    clear  = 1'b0;
    enable = 1'b1;
    tick();
    check_idle("post_reset");

    for (int i = 0; i < 4; i++) begin
      run_burst(i, vecs[i].sel, vecs[i].per, vecs[i].high_len, vecs[i].low_len, -1, 1'b0);
    end

    // Start with different tone/length mid-burst must not disturb the running burst.
    run_burst(10, 1'b0, 8'd2, H1, L1, 7, 1'b0);

    // Start held through DONE is ignored there, then accepted from IDLE.
    run_burst(11, 1'b0, 8'd1, H1, L1, -1, 1'b1);
    run_burst(12, 1'b1, 8'd2, H2, L2, -1, 1'b0);

    // Continuous mode, aborted by enable.
    select  = 1'b0;
    periods = 8'd0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int k = 0; k < 47; k++) begin
      check($sformatf("cont_k%0d_out", k),  out,  ((k % 10) < 5) ? 1'b1 : 1'b0);
      check($sformatf("cont_k%0d_busy", k), busy, 1'b1);
      check($sformatf("cont_k%0d_done", k), done, 1'b0);
      tick();
    end
    enable = 1'b0;
    tick();
    check_idle("cont_abort");
    for (int k = 0; k < 3; k++) begin
      tick();
      check_idle($sformatf("cont_abort_k%0d", k));
    end
    start = 1'b1;
    tick();
    check_idle("start_while_disabled");
    start  = 1'b0;
    enable = 1'b1;
    tick();
    check_idle("reenable");

    // Asynchronous clear in the middle of a HIGH phase.
    select  = 1'b0;
    periods = 8'd3;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    tick();
    tick();
    check("clr_pre_out",  out,  1'b1);
    check("clr_pre_busy", busy, 1'b1);
    #2;
    clear = 1'b1;
    #1;
    check_idle("clr_async");
    #1;
    clear = 1'b0;
    tick();
    check_idle("clr_released");
    run_burst(20, 1'b0, 8'd1, H1, L1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
